multi_reset_generator: RTL and testbench

- Multi-channel, parametrised successor of the single-channel detector RESET pulse generator.
- Each channel produces a periodic or one-shot high pulse on its own output. Each channel has its own high time, low time, start phase and mode.
- All timing is in ticks of a shared internal prescaler, e.g. 1 us ticks from a 100 MHz clk.
- Sits between the host configuration registers and the per-array RESET pins.

---
 rtl/multi_reset_generator.sv | 231 +++++++++++++++++++++++
 tb/tb_multi_reset_generator.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_reset_generator.sv
// multi_reset_generator
//   NUM_CH independent RESET pulse channels timed by one shared prescaler.
//   Each channel runs periodic, one-shot, force-high or force-low.
//   All durations are counted in prescaler ticks.
//
// Ports
//   clk          system clock
//   reset        asynchronous active-low reset; drives rst_out to all 1s
//   enable       per-channel run enable (does not gate force modes)
//   mode         2 bits per channel: 00 periodic, 01 force high, 10 force low, 11 one-shot
//   high_time    CNT_W bits per channel, high duration in ticks
//   low_time     CNT_W bits per channel, low duration in ticks
//   phase        CNT_W bits per channel, initial low delay (periodic only)
//   trigger      per-channel one-shot start level, sampled on ticks
//   tick_out     one-clk prescaler tick
//   rst_out      registered RESET outputs
//   period_done  one-clk pulse per completed period / one-shot pulse
//   period_count 16 bits per channel, saturating period counter
//                (present only with MULTI_RESET_GENERATOR_PERIOD_COUNT_EN defined)
//
// Channel states
//   IDLE  | output low, waiting for enable+tick (periodic) or trigger (one-shot)
//   PHASE | output low, counting down the initial phase delay
//   HIGH  | output high, counting down high_time
//   LOW   | output low, counting down low_time
module multi_reset_generator #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 16,
    parameter int PRESCALE = 100
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       enable,
    input  logic [2*NUM_CH-1:0]     mode,
    input  logic [CNT_W*NUM_CH-1:0] high_time,
    input  logic [CNT_W*NUM_CH-1:0] low_time,
    input  logic [CNT_W*NUM_CH-1:0] phase,
    input  logic [NUM_CH-1:0]       trigger,
    output logic                    tick_out,
    output logic [NUM_CH-1:0]       rst_out,
    output logic [NUM_CH-1:0]       period_done
`ifdef MULTI_RESET_GENERATOR_PERIOD_COUNT_EN
    ,
    output logic [16*NUM_CH-1:0]    period_count
`endif
);

    localparam int              PS_W    = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    localparam logic [1:0] MODE_PERIODIC = 2'b00;
    localparam logic [1:0] MODE_FORCE_HI = 2'b01;
    localparam logic [1:0] MODE_FORCE_LO = 2'b10;
    localparam logic [1:0] MODE_ONE_SHOT = 2'b11;

    typedef enum logic [1:0] {IDLE, PHASE, HIGH, LOW} state_t;

    typedef struct packed {
        state_t           st;
        logic [CNT_W-1:0] cnt;
        logic             out;
    } seg_t;

    // First segment of a period: a zero high_time skips straight to LOW.
    function automatic seg_t period_start(input logic [CNT_W-1:0] h, input logic [CNT_W-1:0] l);
        seg_t s;
        if (h != '0) begin
            s.st  = HIGH;
            s.cnt = h;
            s.out = 1'b1;
        end else begin
            s.st  = LOW;
            s.cnt = l;
            s.out = 1'b0;
        end
        return s;
    endfunction

    logic [PS_W-1:0] ps_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ps_cnt <= '0;
        end else if (ps_cnt == PS_LAST) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + 1'b1;
        end
    end

    assign tick_out = (ps_cnt == PS_LAST);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [1:0]       md;
        logic [CNT_W-1:0] hi_in, lo_in, ph_in;
        logic             forced;
        state_t           state;
        logic [CNT_W-1:0] cnt, hi_q, lo_q;
        logic             one_shot, out_q, done_q;
        seg_t             fresh, held;

        assign md     = mode[2*i +: 2];
        assign hi_in  = high_time[CNT_W*i +: CNT_W];
        assign lo_in  = low_time[CNT_W*i +: CNT_W];
        assign ph_in  = phase[CNT_W*i +: CNT_W];
        assign forced = (md == MODE_FORCE_HI) || (md == MODE_FORCE_LO);
        // fresh: period start from the live fields (re-latch point);
        // held: period start from the fields latched when leaving IDLE.
        assign fresh  = period_start(hi_in, lo_in);
        assign held   = period_start(hi_q, lo_q);

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state    <= IDLE;
                cnt      <= '0;
                hi_q     <= '0;
                lo_q     <= '0;
                one_shot <= 1'b0;
                out_q    <= 1'b1;
                done_q   <= 1'b0;
            end else begin
                done_q <= 1'b0;
                if (forced) begin
                    state <= IDLE;
                    cnt   <= '0;
                    out_q <= (md == MODE_FORCE_HI);
                end else if (!enable[i]) begin
                    state <= IDLE;
                    cnt   <= '0;
                    out_q <= 1'b0;
                end else if (tick_out) begin
                    case (state)
                        IDLE: begin
                            out_q <= 1'b0;
                            if (md == MODE_PERIODIC) begin
                                hi_q     <= hi_in;
                                lo_q     <= lo_in;
                                one_shot <= 1'b0;
                                if (ph_in != '0) begin
                                    state <= PHASE;
                                    cnt   <= ph_in;
                                end else begin
                                    state <= fresh.st;
                                    cnt   <= fresh.cnt;
                                    out_q <= fresh.out;
                                end
                            end else if (md == MODE_ONE_SHOT && trigger[i]) begin
                                hi_q     <= hi_in;
                                one_shot <= 1'b1;
                                if (hi_in != '0) begin
                                    state <= HIGH;
                                    cnt   <= hi_in;
                                    out_q <= 1'b1;
                                end else begin
                                    done_q <= 1'b1;
                                end
                            end
                        end
                        PHASE: begin
                            if (cnt <= ONE) begin
                                state <= held.st;
                                cnt   <= held.cnt;
                                out_q <= held.out;
                            end else begin
                                cnt <= cnt - ONE;
                            end
                        end
                        HIGH: begin
                            if (cnt > ONE) begin
                                cnt <= cnt - ONE;
                            end else if (one_shot) begin
                                state  <= IDLE;
                                cnt    <= '0;
                                out_q  <= 1'b0;
                                done_q <= 1'b1;
                            end else if (lo_q != '0) begin
                                state <= LOW;
                                cnt   <= lo_q;
                                out_q <= 1'b0;
                            end else begin
                                // low_time of zero: period ends here, back-to-back HIGH
                                done_q <= 1'b1;
                                hi_q   <= hi_in;
                                lo_q   <= lo_in;
                                state  <= fresh.st;
                                cnt    <= fresh.cnt;
                                out_q  <= fresh.out;
                            end
                        end
                        LOW: begin
                            if (cnt > ONE) begin
                                cnt <= cnt - ONE;
                            end else begin
                                done_q <= 1'b1;
                                hi_q   <= hi_in;
                                lo_q   <= lo_in;
                                state  <= fresh.st;
                                cnt    <= fresh.cnt;
                                out_q  <= fresh.out;
                            end
                        end
                    endcase
                end else if (state == IDLE) begin
                    // covers reset release and leaving force-high between ticks
                    out_q <= 1'b0;
                end
            end
        end

        assign rst_out[i]     = out_q;
        assign period_done[i] = done_q;

`ifdef MULTI_RESET_GENERATOR_PERIOD_COUNT_EN
        logic [15:0] pcount;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                pcount <= '0;
            end else if (forced || !enable[i]) begin
                pcount <= '0;
            end else if (done_q && pcount != 16'hFFFF) begin
                pcount <= pcount + 16'd1;
            end
        end

        assign period_count[16*i +: 16] = pcount;
`endif
    end

endmodule

// File: tb/tb_multi_reset_generator.sv
module tb_multi_reset_generator;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;
    localparam int P      = 4;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic [NUM_CH-1:0]       enable;
    logic [2*NUM_CH-1:0]     mode;
    logic [CNT_W*NUM_CH-1:0] high_time, low_time, phase;
    logic [NUM_CH-1:0]       trigger;
    logic                    tick_out;
    logic [NUM_CH-1:0]       rst_out, period_done;
`ifdef MULTI_RESET_GENERATOR_PERIOD_COUNT_EN
    logic [16*NUM_CH-1:0]    period_count;
`endif

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    multi_reset_generator #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESCALE(P)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .mode        (mode),
        .high_time   (high_time),
        .low_time    (low_time),
        .phase       (phase),
        .trigger     (trigger),
        .tick_out    (tick_out),
        .rst_out     (rst_out),
        .period_done (period_done)
`ifdef MULTI_RESET_GENERATOR_PERIOD_COUNT_EN
        ,
        .period_count(period_count)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: a channel is a timeline anchored at the tick m_s where
    // its current period begins; position k = ticks since then decides the level.
    int                e_cnt = 0;
    int                n_tick = 0;
    bit                m_act [NUM_CH];
    bit                m_os  [NUM_CH];
    int                m_s   [NUM_CH];
    int                m_h   [NUM_CH];
    int                m_l   [NUM_CH];
    logic [NUM_CH-1:0] exp_out = '1;
    logic [NUM_CH-1:0] exp_done = '0;
    logic              exp_tick;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_cnt    = 0;
            n_tick   = 0;
            exp_out  = '1;
            exp_done = '0;
            for (int c = 0; c < NUM_CH; c++) m_act[c] = 1'b0;
        end else begin
            bit   is_tick;
            int   k, ph;
            logic [1:0] md;
            e_cnt++;
            is_tick = (e_cnt % P == 0);
            if (is_tick) n_tick++;
            for (int c = 0; c < NUM_CH; c++) begin
                md = mode[2*c +: 2];
                exp_done[c] = 1'b0;
                if (md == 2'b01 || md == 2'b10) begin
                    m_act[c]   = 1'b0;
                    exp_out[c] = (md == 2'b01);
                end else if (!enable[c]) begin
                    m_act[c]   = 1'b0;
                    exp_out[c] = 1'b0;
                end else if (!is_tick) begin
                    if (!m_act[c]) exp_out[c] = 1'b0;
                end else if (m_act[c]) begin
                    k = n_tick - m_s[c];
                    if (m_os[c]) begin
                        if (k == m_h[c]) begin
                            exp_done[c] = 1'b1;
                            m_act[c]     = 1'b0;
                            exp_out[c]   = 1'b0;
                        end else begin
                            exp_out[c] = (k < m_h[c]);
                        end
                    end else begin
                        if (k == m_h[c] + m_l[c]) begin
                            exp_done[c] = 1'b1;
                            m_h[c] = int'(high_time[CNT_W*c +: CNT_W]);
                            m_l[c] = int'(low_time[CNT_W*c +: CNT_W]);
                            m_s[c] = n_tick;
                            k = 0;
                        end
                        exp_out[c] = (k >= 0 && k < m_h[c]);
                    end
                end else begin
                    exp_out[c] = 1'b0;
                    if (md == 2'b00) begin
                        ph       = int'(phase[CNT_W*c +: CNT_W]);
                        m_act[c] = 1'b1;
                        m_os[c]  = 1'b0;
                        m_h[c]   = int'(high_time[CNT_W*c +: CNT_W]);
                        m_l[c]   = int'(low_time[CNT_W*c +: CNT_W]);
                        m_s[c]   = n_tick + ph;
                        exp_out[c] = (ph == 0 && m_h[c] > 0);
                    end else if (trigger[c]) begin
                        m_h[c] = int'(high_time[CNT_W*c +: CNT_W]);
                        if (m_h[c] == 0) begin
                            exp_done[c] = 1'b1;
                        end else begin
                            m_act[c]   = 1'b1;
                            m_os[c]    = 1'b1;
                            m_s[c]     = n_tick;
                            exp_out[c] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            exp_tick = reset && ((e_cnt + 1) % P == 0);
            vectors++;
            if (rst_out !== exp_out || period_done !== exp_done || tick_out !== exp_tick) begin
                miscompares++;
                $display("FAIL model_cycle t=%0t: rst_out got %b want %b, period_done got %b want %b, tick_out got %b want %b",
                         $time, rst_out, exp_out, period_done, exp_done, tick_out, exp_tick);
            end
        end
    end

    // Edge/pulse bookkeeping for the hand-computed checks.
    int                cyc = 0;
    int                rises [NUM_CH] = '{default: 0};
    int                falls [NUM_CH] = '{default: 0};
    int                dcnt  [NUM_CH] = '{default: 0};
    int                last_done [NUM_CH] = '{default: 0};
    int                prev_done [NUM_CH] = '{default: 0};
    logic [NUM_CH-1:0] prev_out = '1;

    always @(posedge clk) begin
        #1;
        if (!reset) cyc = 0;
        else cyc++;
        for (int c = 0; c < NUM_CH; c++) begin
            if (!prev_out[c] && rst_out[c]) rises[c]++;
            if (prev_out[c] && !rst_out[c]) falls[c]++;
            if (period_done[c]) begin
                dcnt[c]++;
                prev_done[c] = last_done[c];
                last_done[c] = cyc;
            end
        end
        prev_out = rst_out;
    end

    task automatic chk(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic set_ch(input int c, input logic [1:0] m, input int h, input int l, input int p);
        mode[2*c +: 2]               = m;
        high_time[CNT_W*c +: CNT_W]  = CNT_W'(h);
        low_time[CNT_W*c +: CNT_W]   = CNT_W'(l);
        phase[CNT_W*c +: CNT_W]      = CNT_W'(p);
    endtask

    task automatic set_mode(input int c, input logic [1:0] m);
        mode[2*c +: 2] = m;
    endtask

    task automatic wait_level(input int c, input logic v, input int max_clk, output int at);
        int n = 0;
        while (rst_out[c] !== v && n < max_clk) begin
            @(negedge clk);
            n++;
        end
        if (rst_out[c] !== v) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_ch%0d: level %b not reached within %0d clks", c, v, max_clk);
        end
        at = cyc;
    endtask

    task automatic wait_tick(output int at);
        int n = 0;
        while (tick_out !== 1'b1 && n < 2 * P) begin
            @(negedge clk);
            n++;
        end
        if (tick_out !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_tick: no tick within %0d clks", 2 * P);
        end
        at = cyc + 1;
    endtask

    initial begin
        int r, f, r2, e1, t, snap;
        enable    = '0;
        mode      = '0;
        high_time = '0;
        low_time  = '0;
        phase     = '0;
        trigger   = '0;
        #1 reset = 1'b0;
        chk_en = 1'b1;

        set_ch(0, 2'b00, 2, 3, 0);
        set_ch(1, 2'b00, 0, 7, 0);
        set_ch(2, 2'b00, 3, 0, 0);
        set_ch(3, 2'b11, 5, 0, 0);
        enable = '1;
        repeat (2) @(negedge clk);
        chk("reset_hold", int'(rst_out), 15);
        reset = 1'b1;
        @(negedge clk);
        chk("release_low", int'(rst_out), 0);

        // periodic ch0 high=2 low=3: 8 clks high, 20 clk period
        wait_level(0, 1'b1, 40, r);
        chk("ch0_first_rise", r, 4);
        wait_level(0, 1'b0, 40, f);
        chk("ch0_high_width", f - r, 8);
        wait_level(0, 1'b1, 40, r2);
        chk("ch0_period", r2 - r, 20);
        wait_level(2, 1'b1, 40, r);
        snap = falls[2];
        while (cyc < 70) @(negedge clk);
        chk("ch0_done_spacing", last_done[0] - prev_done[0], 20);
        chk("ch1_done_spacing", last_done[1] - prev_done[1], 28);
        chk("ch1_never_high", rises[1], 0);
        chk("ch2_never_falls", falls[2] - snap, 0);
        chk("ch2_level", int'(rst_out[2]), 1);
        chk("ch3_idle", rises[3], 0);

        // one-shot ch3: single 5-tick pulse, retrigger inside pulse ignored
        wait_tick(e1);
        trigger[3] = 1'b1;
        @(negedge clk);
        trigger[3] = 1'b0;
        wait_level(3, 1'b1, 8, r);
        chk("ch3_rise_at_tick", r, e1);
        repeat (8) @(negedge clk);
        wait_tick(t);
        trigger[3] = 1'b1;
        @(negedge clk);
        trigger[3] = 1'b0;
        wait_level(3, 1'b0, 40, f);
        chk("ch3_width", f - r, 20);
        chk("ch3_retrig_inside", int'(t > r && t < f), 1);
        repeat (12) @(negedge clk);
        chk("ch3_single_pulse", rises[3], 1);
        chk("ch3_single_done", dcnt[3], 1);

        // high 2 -> 6 during LOW: current LOW unchanged, next width 24 clks
        wait_level(0, 1'b1, 40, r);
        wait_level(0, 1'b0, 40, f);
        high_time[15:0] = 16'd6;
        wait_level(0, 1'b1, 40, r);
        chk("ch0_low_unchanged", r - f, 12);
        wait_level(0, 1'b0, 60, f);
        chk("ch0_new_width", f - r, 24);

        // force modes
        wait_level(0, 1'b1, 60, r);
        @(negedge clk);
        set_mode(0, 2'b01);
        set_mode(1, 2'b01);
        @(negedge clk);
        chk("force_hi_ch1", int'(rst_out[1]), 1);
        chk("force_hi_ch0", int'(rst_out[0]), 1);
        repeat (30) @(negedge clk);
        chk("force_hi_hold", int'(rst_out[0]), 1);
        set_mode(0, 2'b10);
        @(negedge clk);
        chk("force_lo_ch0", int'(rst_out[0]), 0);
        set_mode(1, 2'b00);

        // disable
        enable[2] = 1'b0;
        @(negedge clk);
        chk("disable_ch2", int'(rst_out[2]), 0);
        enable[2] = 1'b1;

        // phase 5: first rise 20 clks after the first tick, then 20 clk period
        high_time[15:0] = 16'd2;
        phase[15:0]     = 16'd5;
        set_mode(0, 2'b00);
        wait_tick(e1);
        wait_level(0, 1'b1, 40, r);
        chk("phase_first_rise", r - e1, 20);
        wait_level(0, 1'b0, 40, f);
        wait_level(0, 1'b1, 40, r2);
        chk("phase_period", r2 - r, 20);

        // asynchronous reset mid-period
        @(negedge clk);
        #2 reset = 1'b0;
        #1 chk("async_reset", int'(rst_out), 15);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("release_after_mid", int'(rst_out), 0);
        repeat (10) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
